line_pingpong_accum: RTL
========================

Name: line_pingpong_accum

Overview:
- Parametrised successor of the coprocessor's pixel-line accumulator. Collects a stream of packed RGB pixels into one of two line banks (ping-pong).
- Presents each completed line as a single wide word to the bank-write stage, using a valid/ready handshake in both directions.
- Adds backpressure, explicit line completion, and flush of partial lines, none of which the fixed 256×12 version had.

Parameters:
- PIX_W, 12, bits per pixel (R [11:8], G [7:4], B [3:0] at default).
- LINE_PIX, 256, pixels per line; must be ≥2.
- CNT_W, $clog2(LINE_PIX+1), width of the fill counter (derived; do not override).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- pix_valid  in  1  upstream pixel valid.
- pix_data  in  PIX_W  pixel value.
- pix_ready  out  1  accumulator can accept a pixel this cycle.
- flush  in  1  single-cycle pulse; close the current partial line.
- line_valid  out  1  a full or flushed line is presented on line_data.
- line_ready  in  1  downstream consumes the presented line.
- line_data  out  LINE_PIX*PIX_W  presented line; pixel i at bits [i*PIX_W +: PIX_W], pixel 0 at LSB.
- line_len  out  CNT_W  number of valid pixels in the presented line (LINE_PIX unless flushed).
- fill_cnt  out  CNT_W  pixels written into the filling bank so far.

Behaviour:
- Storage and pointers:
  - Two banks B0/B1, each LINE_PIX*PIX_W bits.
  - Per-bank state EMPTY / FILLING / FULL.
  - wr_sel selects the filling bank; rd_sel selects the presented bank.
- Reset (async, any time, including mid-line):
  - Banks cleared to 0; both banks EMPTY; wr_sel=0, rd_sel=0, fill_cnt=0.
  - Outputs: line_valid=0, line_data=0, line_len=0, pix_ready=1. Pixels in flight are discarded.
- Pixel accept:
  - A pixel is accepted when pix_valid & pix_ready.
  - pix_data is written to slot fill_cnt of bank[wr_sel] (indexed write, not shift); fill_cnt increments.
  - The first accept moves the bank EMPTY→FILLING.
- pix_ready = (bank[wr_sel] != FULL). Combinational from registered state only; no combinational path from pix_valid.
- Line close on full:
  - When the accept makes fill_cnt reach LINE_PIX, the bank goes →FULL and its length is latched as LINE_PIX.
  - fill_cnt clears to 0 and wr_sel toggles, all in the same edge.
- Line close on flush:
  - flush with fill_cnt>0: bank →FULL, latched length = fill_cnt (plus 1 if a pixel is accepted in the same cycle; that pixel is included). Then fill_cnt=0 and wr_sel toggles.
  - flush with fill_cnt==0 and no accepted pixel: ignored.
  - flush while bank[wr_sel] is FULL: ignored.
- Output:
  - line_valid = (bank[rd_sel]==FULL).
  - line_data = bank[rd_sel]; line_len = latched length of bank[rd_sel].
  - line_data and line_len are stable while line_valid is high and line_ready is low.
- Release: on line_valid & line_ready, bank[rd_sel] →EMPTY and rd_sel toggles.
- Latency: last pixel (or flush) accepted at edge N → line_valid=1 after edge N, visible in cycle N+1.
- Both banks FULL: pix_ready=0. Upstream stalls; no pixel is lost or overwritten.
- Simultaneous release and line close in the same cycle: both take effect.
  - Release empties bank[rd_sel] while the other bank becomes FULL.
  - Next cycle line_valid stays 1, presenting the other bank.
- Wrap-around: no limit on the number of lines; wr_sel and rd_sel alternate indefinitely.
- Slots not written in a flushed line hold stale data (see optional feature).

Optional Feature:
- Macro: LINE_PING_PONG_ACCUM_CLR_EN.
- Defined: on release, the released bank is zeroed in the same edge. Unwritten slots of a flushed line therefore read 0.
- Not defined: banks are never cleared after reset. Unwritten slots of a flushed line hold the previous line's pixels. Saves the clear logic.

Test Plan (PIX_W=12, LINE_PIX=4):
- Reset, then stream 0x111,0x222,0x333,0x444 with line_ready=0:
  - line_valid=1 one cycle after the 4th accept.
  - line_data=0x444333222111, line_len=4.
  - pix_ready stays 1 (B1 filling).
- Stream 8 pixels 0x001..0x008 with line_ready=0:
  - pix_ready=0 after the 8th accept.
  - A 9th pixel is held, not lost.
  - line_ready=1 for one cycle → line_data 0x004003002001, then 0x008007006005; the 9th pixel is then accepted.
- 0xAAA,0xBBB, then flush, with CLR_EN defined and previous line 0x444333222111 released:
  - line_len=2, line_data=0x000000BBBAAA.
  - Without CLR_EN: line_data=0x444333BBBAAA.
- Flush pulsed with fill_cnt=0 → no line_valid, no pointer change.
- Flush in the same cycle as the 3rd pixel accept → line_len=3, pixel 3 present.
- Assert rst while fill_cnt=2 and one bank is FULL:
  - Immediately line_valid=0, fill_cnt=0, pix_ready=1.
  - A following 4-pixel line appears in B0 with line_len=4.

Source files
------------

// File: rtl/line_pingpong_accum.sv
// rtl/line_pingpong_accum.sv - ping-pong pixel line accumulator with valid/ready line output
// Optional: define LINE_PING_PONG_ACCUM_CLR_EN to zero a bank when its line is released.
module line_pingpong_accum #(
    parameter int PIX_W    = 12,
    parameter int LINE_PIX = 256,
    parameter int CNT_W    = $clog2(LINE_PIX + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pix_valid,
    input  logic [PIX_W-1:0]          pix_data,
    output logic                      pix_ready,
    input  logic                      flush,
    output logic                      line_valid,
    input  logic                      line_ready,
    output logic [LINE_PIX*PIX_W-1:0] line_data,
    output logic [CNT_W-1:0]          line_len,
    output logic [CNT_W-1:0]          fill_cnt
);

    localparam int LW = LINE_PIX * PIX_W;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_st_e;

    bank_st_e         st_q   [2];
    bank_st_e         st_d   [2];
    logic [LW-1:0]    bank_q [2];
    logic [LW-1:0]    bank_d [2];
    logic [CNT_W-1:0] len_q  [2];
    logic [CNT_W-1:0] len_d  [2];
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;

    logic             accept;
    logic             rel;
    logic             close;
    logic [CNT_W-1:0] new_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                st_q[b]   <= EMPTY;
                bank_q[b] <= '0;
                len_q[b]  <= '0;
            end
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            fill_cnt_q <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                st_q[b]   <= st_d[b];
                bank_q[b] <= bank_d[b];
                len_q[b]  <= len_d[b];
            end
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    // Release and fill never target the same bank: release needs FULL, fill needs not FULL.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            st_d[b]   = st_q[b];
            bank_d[b] = bank_q[b];
            len_d[b]  = len_q[b];
        end
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        fill_cnt_d = fill_cnt_q;

        if (rel) begin
            st_d[rd_sel_q] = EMPTY;
            rd_sel_d       = ~rd_sel_q;
`ifdef LINE_PING_PONG_ACCUM_CLR_EN
            bank_d[rd_sel_q] = '0;
`endif
        end

        if (accept) begin
            bank_d[wr_sel_q][fill_cnt_q*PIX_W +: PIX_W] = pix_data;
            st_d[wr_sel_q] = FILLING;
            fill_cnt_d     = new_cnt;
        end

        if (close) begin
            st_d[wr_sel_q]  = FULL;
            len_d[wr_sel_q] = new_cnt;
            fill_cnt_d      = '0;
            wr_sel_d        = ~wr_sel_q;
        end
    end

    always_comb begin
        pix_ready  = (st_q[wr_sel_q] != FULL);
        line_valid = (st_q[rd_sel_q] == FULL);
        line_data  = bank_q[rd_sel_q];
        line_len   = len_q[rd_sel_q];
        fill_cnt   = fill_cnt_q;
        accept     = pix_valid & pix_ready;
        rel        = line_valid & line_ready;
        new_cnt    = fill_cnt_q + CNT_W'(accept);
        close      = pix_ready & ((accept & (new_cnt == CNT_W'(LINE_PIX)))
                                | (flush & (new_cnt != '0)));
    end

endmodule
